lookup_table_mc: RTL and testbench
==================================

LOOKUP_TABLE_MC -- requirements
Module: lookup_table_mc

Interface
REQ-001 SHALL provide these parameters (name, default, meaning):
- ADDR_REG, 0, GPIO register address that loads the write pointer.
- DATA_REG, 1, GPIO register address that carries table data.
- CTRL_REG, 2, GPIO register address for control.
- IN_BITS, 10, lookup index width; table depth is 2^IN_BITS.
- OUT_BITS, 16, entry width, 1..32.
- CHANNELS, 2, number of independent lookup ports.

REQ-002 SHALL provide these ports (name, direction, width, meaning):
- clk, in, 1, the only clock.
- rst, in, 1, reset: synchronous, active-low.
- gpio_in, in, 32, GPIO bus: [31] write strobe, [23:16] register address, [15:0] data.
- val_in, in, CHANNELS*IN_BITS, per-channel index; channel c occupies [c*IN_BITS +: IN_BITS].
- val_in_valid, in, CHANNELS, per-channel index qualifier.
- val_out, out, CHANNELS*OUT_BITS, per-channel result; channel c occupies [c*OUT_BITS +: OUT_BITS].
- val_out_valid, out, CHANNELS, per-channel result qualifier.
- bank_sel, out, 1, index of the active (read) bank.
- swap_pending, out, 1, a bank swap has been requested but not yet applied.

Function
REQ-003 SHALL register gpio_in[31] and treat each 0->1 transition as exactly one write event, decoded against gpio_in[23:16] in the cycle the rising edge is detected.
- A strobe held high SHALL NOT produce repeated events.
- A write event to an unmatched register address SHALL be ignored.

REQ-004 A write event to ADDR_REG SHALL load the write pointer with gpio_in[IN_BITS-1:0] and discard any partially assembled entry.

REQ-005 Entry assembly SHALL take W writes to DATA_REG, where W=1 if OUT_BITS<=16 and W=2 otherwise.
- When W=2, the first write supplies the upper OUT_BITS-16 bits; the second write supplies the lower 16 bits.

REQ-006 On the W-th DATA_REG write, the assembled entry SHALL be written to the shadow bank at the write pointer.
- The pointer then increments modulo 2^IN_BITS (2^IN_BITS-1 wraps to 0).

REQ-007 A write event to CTRL_REG SHALL act on the data bits as follows:
- bit0=1 sets swap_pending.
- bit1=1 clears the write pointer and the partial entry.
- Both bits may be set in the same write.

REQ-008 While swap_pending=1, the swap SHALL be applied in the first cycle in which val_in_valid is all zeros. In that cycle bank_sel toggles and swap_pending clears.

REQ-009 A swap request arriving while swap_pending=1 SHALL be absorbed; it produces no second toggle.

REQ-010 Every channel SHALL read identical table contents from the active bank; memory may be replicated per channel.

REQ-011 Lookup latency SHALL be exactly 2 cycles.
- val_out_valid[c] equals val_in_valid[c] delayed by 2 cycles.
- val_out[c] updates only when a valid result emerges and otherwise holds its last value.
- Full throughput: one lookup per channel per cycle.

REQ-012 A lookup SHALL use the bank that was active in the cycle its val_in_valid was sampled. A swap SHALL NOT corrupt lookups already in flight.

REQ-013 DATA_REG writes SHALL always target the bank opposite bank_sel, including writes made while swap_pending=1.

Reset
REQ-014 With rst=0 at a clk edge, the block SHALL clear:
- val_out and val_out_valid to 0.
- bank_sel and swap_pending to 0.
- The write pointer, the partial entry and the strobe history to 0.
- All in-flight pipeline valids.

REQ-015 Reset SHALL NOT clear table memory contents.
- A partially assembled entry is discarded.
- After reset release, the strobe history is 0, so a strobe that is still high is seen as a new rising edge.

Configuration
REQ-016 Macro LUT_DOUBLE_BUFFER_EN SHALL select the buffering mode.
- Defined: two banks, with shadow writes and swap as in REQ-006 to REQ-013.
- Undefined: a single bank. DATA_REG writes go directly to the read table, CTRL_REG bit0 is ignored, and bank_sel and swap_pending are tied to 0.
- Undefined, same-cycle write and read of one address: the lookup SHALL return the old entry.

Verification
REQ-017 Single-write load (OUT_BITS=16, double buffer on): ADDR_REG=5, DATA_REG 0x1234, 0xABCD, CTRL 0x1 with inputs idle; then channel 0 index 6 -> val_out[0]=0xABCD exactly 2 cycles later, bank_sel=1.

REQ-018 Wide entry (OUT_BITS=24): ADDR_REG=0, DATA_REG 0x00AB then 0xCDEF, swap; lookup index 0 -> 0xABCDEF, and the write pointer reads back as 1 via a subsequent write to index 1.

REQ-019 Deferred swap: hold val_in_valid=2'b11 continuously, issue CTRL 0x1 -> swap_pending=1 and bank_sel unchanged; drop valid for one cycle -> bank_sel toggles that cycle; results in flight keep old-bank values.

REQ-020 Pointer wrap and strobe hold (IN_BITS=4): ADDR_REG=15, write 0x0011 then 0x0022 with the strobe held high 5 cycles on the second write -> index 15=0x0011, index 0=0x0022, index 1 unchanged.

REQ-021 Reset mid-operation: assert rst after the first half of a 24-bit entry and during swap_pending=1 -> all outputs 0, swap_pending=0; previously swapped-in contents still read back correctly.

REQ-022 Without LUT_DOUBLE_BUFFER_EN: in the same cycle, write index 3=0x5555 (old 0x1111) and look up index 3 -> result 0x1111; the next lookup of index 3 -> 0x5555.

Source files
------------

// File: rtl/lookup_table_mc.sv
`default_nettype none
// ============================================================================
// Module      : lookup_table_mc
// Description : Multi-channel lookup table loaded over a GPIO register bus,
//               2-cycle lookup latency. Macro LUT_DOUBLE_BUFFER_EN selects
//               shadow/active double buffering with deferred bank swap.
// Revision    : 1.0 - initial release
// ============================================================================
module lookup_table_mc #(
    parameter int ADDR_REG = 0,
    parameter int DATA_REG = 1,
    parameter int CTRL_REG = 2,
    parameter int IN_BITS  = 10,
    parameter int OUT_BITS = 16,
    parameter int CHANNELS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  gpio_in,
    input  logic [CHANNELS*IN_BITS-1:0]  val_in,
    input  logic [CHANNELS-1:0]          val_in_valid,
    output logic [CHANNELS*OUT_BITS-1:0] val_out,
    output logic [CHANNELS-1:0]          val_out_valid,
    output logic                         bank_sel,
    output logic                         swap_pending
);

`ifdef LUT_DOUBLE_BUFFER_EN
    localparam int AW = IN_BITS + 1;
`else
    localparam int AW = IN_BITS;
`endif
    localparam bit WIDE = (OUT_BITS > 16);

    logic                strobe_d1;
    logic [IN_BITS-1:0]  wr_ptr;
    logic [15:0]         hi_part;
    logic                part_valid;
    logic                write_event;
    logic                addr_ev;
    logic                data_ev;
    logic                ctrl_ev;
    logic                data_last;
    logic [31:0]         entry_full;
    logic [OUT_BITS-1:0] wr_data;
    logic [AW-1:0]       wr_addr;
    logic                unused_bits;

    // Events are gated by reset so nothing reaches the table while in reset.
    assign write_event = rst && gpio_in[31] && !strobe_d1;
    assign addr_ev     = write_event && (gpio_in[23:16] == 8'(ADDR_REG));
    assign data_ev     = write_event && (gpio_in[23:16] == 8'(DATA_REG));
    assign ctrl_ev     = write_event && (gpio_in[23:16] == 8'(CTRL_REG));
    assign data_last   = data_ev && (!WIDE || part_valid);
    assign entry_full  = WIDE ? {hi_part, gpio_in[15:0]} : {16'h0000, gpio_in[15:0]};
    assign wr_data     = entry_full[OUT_BITS-1:0];
    assign unused_bits = &{1'b0, gpio_in[30:24], entry_full};

    always_ff @(posedge clk) begin
        if (!rst) begin
            strobe_d1  <= 1'b0;
            wr_ptr     <= '0;
            hi_part    <= '0;
            part_valid <= 1'b0;
        end else begin
            strobe_d1 <= gpio_in[31];
            if (addr_ev) begin
                wr_ptr     <= gpio_in[IN_BITS-1:0];
                part_valid <= 1'b0;
            end else if (ctrl_ev && gpio_in[1]) begin
                wr_ptr     <= '0;
                part_valid <= 1'b0;
            end else if (data_ev) begin
                if (data_last) begin
                    wr_ptr     <= wr_ptr + 1'b1;
                    part_valid <= 1'b0;
                end else begin
                    hi_part    <= gpio_in[15:0];
                    part_valid <= 1'b1;
                end
            end
        end
    end

`ifdef LUT_DOUBLE_BUFFER_EN
    // Swap waits for an idle cycle so no lookup straddles the bank change.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bank_sel     <= 1'b0;
            swap_pending <= 1'b0;
        end else if (swap_pending && (val_in_valid == '0)) begin
            bank_sel     <= !bank_sel;
            swap_pending <= 1'b0;
        end else if (ctrl_ev && gpio_in[0]) begin
            swap_pending <= 1'b1;
        end
    end
    assign wr_addr = {!bank_sel, wr_ptr};
`else
    assign bank_sel     = 1'b0;
    assign swap_pending = 1'b0;
    assign wr_addr      = wr_ptr;
`endif

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
            logic [OUT_BITS-1:0] mem [0:(1<<AW)-1];
            logic [OUT_BITS-1:0] rd_data;
            logic [OUT_BITS-1:0] out_data;
            logic                rd_valid;
            logic                out_valid;
            logic [AW-1:0]       rd_addr;

`ifdef LUT_DOUBLE_BUFFER_EN
            assign rd_addr = {bank_sel, val_in[c*IN_BITS +: IN_BITS]};
`else
            assign rd_addr = val_in[c*IN_BITS +: IN_BITS];
`endif

            // Read and write share an edge, so a same-cycle hit returns the old entry.
            always_ff @(posedge clk) begin
                if (data_last) begin
                    mem[wr_addr] <= wr_data;
                end
                rd_data <= mem[rd_addr];
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    rd_valid  <= 1'b0;
                    out_valid <= 1'b0;
                    out_data  <= '0;
                end else begin
                    rd_valid  <= val_in_valid[c];
                    out_valid <= rd_valid;
                    if (rd_valid) begin
                        out_data <= rd_data;
                    end
                end
            end

            assign val_out[c*OUT_BITS +: OUT_BITS] = out_data;
            assign val_out_valid[c]                = out_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_lookup_table_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_lookup_table_mc
// Description : Self-checking bench for lookup_table_mc (IN_BITS=4,
//               OUT_BITS=24); expectations follow LUT_DOUBLE_BUFFER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lookup_table_mc;
    localparam int IB = 4;
    localparam int OB = 24;
    localparam int CH = 2;
    localparam logic [7:0] RA = 8'd0;
    localparam logic [7:0] RD = 8'd1;
    localparam logic [7:0] RC = 8'd2;
`ifdef LUT_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [31:0]    gpio_in = '0;
    logic [CH*IB-1:0] val_in = '0;
    logic [CH-1:0]  val_in_valid = '0;
    logic [CH*OB-1:0] val_out;
    logic [CH-1:0]  val_out_valid;
    logic           bank_sel;
    logic           swap_pending;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct { logic [OB-1:0] exp; int due; } sb_t;
    sb_t q0[$];
    sb_t q1[$];

    typedef struct {
        logic [1:0]    vld;
        logic [IB-1:0] i0, i1;
        logic [OB-1:0] e0, e1;
    } vec_t;
    vec_t vecs[6];

    lookup_table_mc #(
        .ADDR_REG(0), .DATA_REG(1), .CTRL_REG(2),
        .IN_BITS(IB), .OUT_BITS(OB), .CHANNELS(CH)
    ) dut (
        .clk(clk), .rst(rst), .gpio_in(gpio_in),
        .val_in(val_in), .val_in_valid(val_in_valid),
        .val_out(val_out), .val_out_valid(val_out_valid),
        .bank_sel(bank_sel), .swap_pending(swap_pending)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Output side of the scoreboard: every emerging result must match the queue head.
    sb_t            mon_e;
    logic [OB-1:0]  mon_got;
    always @(negedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (val_out_valid[c]) begin
                mon_got = val_out[c*OB +: OB];
                if (((c == 0) ? q0.size() : q1.size()) == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid ch%0d: got 0x%0h expected no result", c, mon_got);
                end else begin
                    mon_e = (c == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("lookup_ch%0d", c), 64'(mon_got), 64'(mon_e.exp));
                    check($sformatf("latency_ch%0d", c), 64'(cyc), 64'(mon_e.due));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [OB-1:0] e);
        sb_t s;
        s.exp = e;
        s.due = cyc + 2;
        if (c == 0) q0.push_back(s);
        else        q1.push_back(s);
    endtask

    task automatic set_lane(input int c, input logic [IB-1:0] idx, input logic [OB-1:0] e);
        val_in[c*IB +: IB] = idx;
        val_in_valid[c] = 1'b1;
        push(c, e);
    endtask

    task automatic both(input logic [IB-1:0] i0, input logic [IB-1:0] i1,
                        input logic [OB-1:0] e0, input logic [OB-1:0] e1);
        set_lane(0, i0, e0);
        set_lane(1, i1, e1);
        tick();
    endtask

    task automatic drain();
        val_in_valid = '0;
        repeat (3) tick();
    endtask

    task automatic gpio_wr(input logic [7:0] ra, input logic [15:0] d, input int hold);
        gpio_in = {1'b1, 7'd0, ra, d};
        repeat (hold) tick();
        gpio_in[31] = 1'b0;
        tick();
    endtask

    task automatic load_entry(input logic [OB-1:0] d);
        gpio_wr(RD, {8'h00, d[23:16]}, 1);
        gpio_wr(RD, d[15:0], 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected normal finish");
        $fatal(1);
    end

    initial begin
        logic [OB-1:0] old0, old1;
        vecs[0] = '{vld: 2'b11, i0: 4'd0, i1: 4'd1, e0: 24'hABCDEF, e1: 24'h123456};
        vecs[1] = '{vld: 2'b01, i0: 4'd2, i1: 4'd0, e0: 24'h0F0F0F, e1: 24'h000000};
        vecs[2] = '{vld: 2'b10, i0: 4'd0, i1: 4'd3, e0: 24'h000000, e1: 24'hFFFFFF};
        vecs[3] = '{vld: 2'b11, i0: 4'd3, i1: 4'd0, e0: 24'hFFFFFF, e1: 24'hABCDEF};
        vecs[4] = '{vld: 2'b00, i0: 4'd0, i1: 4'd0, e0: 24'h000000, e1: 24'h000000};
        vecs[5] = '{vld: 2'b11, i0: 4'd1, i1: 4'd2, e0: 24'h123456, e1: 24'h0F0F0F};

        // Reset state
        repeat (3) tick();
        check("rst_val_out", 64'(val_out), 64'h0);
        check("rst_val_out_valid", 64'(val_out_valid), 64'h0);
        check("rst_bank_sel", 64'(bank_sel), 64'h0);
        check("rst_swap_pending", 64'(swap_pending), 64'h0);
        rst = 1'b1;
        tick();

        // Load four wide entries from index 0, then swap them in
        gpio_wr(RA, 16'h0000, 1);
        load_entry(24'hABCDEF);
        load_entry(24'h123456);
        load_entry(24'h0F0F0F);
        load_entry(24'hFFFFFF);
        gpio_wr(RC, 16'h0001, 1);
        check("load_bank_sel", 64'(bank_sel), 64'(DB));

        // Table-driven back-to-back lookups
        for (int v = 0; v < 6; v++) begin
            val_in = {vecs[v].i1, vecs[v].i0};
            val_in_valid = vecs[v].vld;
            if (vecs[v].vld[0]) push(0, vecs[v].e0);
            if (vecs[v].vld[1]) push(1, vecs[v].e1);
            tick();
        end
        drain();

        // Deferred swap under continuous valid, with a second absorbed request
        gpio_wr(RA, 16'h0000, 1);
        load_entry(24'h111111);
        load_entry(24'h222222);
        old0 = DB ? 24'hABCDEF : 24'h111111;
        old1 = DB ? 24'h123456 : 24'h222222;
        both(4'd0, 4'd1, old0, old1);
        gpio_in = {1'b1, 7'd0, RC, 16'h0001};
        both(4'd0, 4'd1, old0, old1);
        check("defer_pending", 64'(swap_pending), 64'(DB));
        check("defer_bank_hold", 64'(bank_sel), 64'(DB));
        gpio_in[31] = 1'b0;
        both(4'd0, 4'd1, old0, old1);
        gpio_in = {1'b1, 7'd0, RC, 16'h0001};
        both(4'd0, 4'd1, old0, old1);
        gpio_in[31] = 1'b0;
        both(4'd0, 4'd1, old0, old1);
        check("absorb_pending", 64'(swap_pending), 64'(DB));
        check("absorb_bank_hold", 64'(bank_sel), 64'(DB));
        val_in_valid = '0;
        tick();
        check("swap_bank_sel", 64'(bank_sel), 64'h0);
        check("swap_pending_clr", 64'(swap_pending), 64'h0);
        tick();
        tick();
        check("single_toggle", 64'(bank_sel), 64'h0);
        both(4'd0, 4'd1, 24'h111111, 24'h222222);
        drain();

        // Pointer wrap and strobe held high on the final write
        gpio_wr(RA, 16'h000F, 1);
        gpio_wr(RD, 16'h0000, 1);
        gpio_wr(RD, 16'h0011, 1);
        gpio_wr(RD, 16'h0000, 1);
        gpio_wr(RD, 16'h0022, 5);
        gpio_wr(RC, 16'h0001, 1);
        check("wrap_bank_sel", 64'(bank_sel), 64'(DB));
        both(4'd15, 4'd0, 24'h000011, 24'h000022);
        both(4'd1, 4'd2, DB ? 24'h123456 : 24'h222222, 24'h0F0F0F);
        drain();

        // Reset with a half entry assembled and a swap pending
        gpio_wr(RA, 16'h0004, 1);
        gpio_wr(RD, 16'h00AA, 1);
        set_lane(0, 4'd2, 24'h0F0F0F);
        gpio_in = {1'b1, 7'd0, RC, 16'h0001};
        tick();
        gpio_in[31] = 1'b0;
        set_lane(0, 4'd2, 24'h0F0F0F);
        tick();
        check("mid_pending", 64'(swap_pending), 64'(DB));
        rst = 1'b0;
        val_in_valid = '0;
        @(negedge clk);
        #1;
        q0.delete();
        q1.delete();
        tick();
        check("mrst_val_out", 64'(val_out), 64'h0);
        check("mrst_val_out_valid", 64'(val_out_valid), 64'h0);
        check("mrst_swap_pending", 64'(swap_pending), 64'h0);
        check("mrst_bank_sel", 64'(bank_sel), 64'h0);
        gpio_in = {1'b1, 7'd0, RA, 16'h0005};
        tick();
        rst = 1'b1;
        tick();
        gpio_in[31] = 1'b0;
        both(4'd0, 4'd1, DB ? 24'h111111 : 24'h000022, 24'h222222);
        drain();
        load_entry(24'h123456);
        gpio_wr(RC, 16'h0001, 1);
        both(4'd5, 4'd0, 24'h123456, 24'h000022);
        drain();

        // Pointer clear via control bit1 discards a partial entry
        gpio_wr(RA, 16'h0009, 1);
        gpio_wr(RD, 16'h0099, 1);
        gpio_wr(RC, 16'h0002, 1);
        load_entry(24'h777777);
        gpio_wr(RC, 16'h0001, 1);
        check("clr_bank_sel", 64'(bank_sel), 64'h0);
        set_lane(0, 4'd0, 24'h777777);
        tick();
        drain();

        // Write and lookup of the same index in the same cycle
        gpio_wr(RA, 16'h0001, 1);
        gpio_wr(RD, 16'h0055, 1);
        gpio_in = {1'b1, 7'd0, RD, 16'h5555};
        set_lane(0, 4'd1, 24'h222222);
        tick();
        gpio_in[31] = 1'b0;
        set_lane(0, 4'd1, DB ? 24'h222222 : 24'h555555);
        tick();
        drain();
        tick();

        check("drained_ch0", 64'(q0.size()), 64'h0);
        check("drained_ch1", 64'(q1.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
